rx_block_sync_ctrl: RTL and testbench

- Receive-side 64B/66B block-synchronisation controller.
- Watches the 2-bit sync header delivered by the transceiver gearbox and walks the gearbox bit position with `o_rx_slipbit` until headers are consistently legal.
- Asserts `o_block_lock` once locked, and drops lock (then resumes slipping) when the header error rate in a window exceeds a threshold.
- Sits between the GT RX gearbox outputs and the PHY RX decoder; the decoder qualifies its data with `o_block_lock`.

---
 rtl/rx_block_sync_ctrl_if.sv | 22 ++
 rtl/rx_block_sync_ctrl.sv | 123 ++++++++++++
 tb/tb_rx_block_sync_ctrl.sv | 311 +++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/rx_block_sync_ctrl_if.sv
// Gearbox-to-sync-controller header/slip bundle.
// Master is the gearbox side; slave is the sync controller.
interface rx_block_sync_ctrl_if;
  logic [1:0] header;
  logic       header_valid;
  logic       slipbit;
  logic       block_lock;

  modport master (
    output header,
    output header_valid,
    input  slipbit,
    input  block_lock
  );

  modport slave (
    input  header,
    input  header_valid,
    output slipbit,
    output block_lock
  );
endinterface

// File: rtl/rx_block_sync_ctrl.sv
// 64B/66B receive block-sync controller.
// Slips the gearbox until sync headers are legal, then monitors error rate.
module rx_block_sync_ctrl #(
  parameter int P_SH_WINDOW    = 64,
  parameter int P_SH_INVLD_MAX = 16,
  parameter int P_SLIP_WAIT    = 32
) (
  input  logic        i_rx_clk,
  input  logic        i_rx_rst,
  input  logic [1:0]  i_rx_header,
  input  logic        i_rx_header_valid,
  output logic        o_rx_slipbit,
  output logic        o_block_lock,
  output logic [15:0] o_slip_cnt,
  output logic [15:0] o_lock_loss_cnt
);

  localparam int W_WIN  = $clog2(P_SH_WINDOW) + 1;
  localparam int W_ERR  = $clog2(P_SH_INVLD_MAX) + 1;
  localparam int W_WAIT = $clog2(P_SLIP_WAIT) + 1;

  typedef enum logic [1:0] {
    S_UNLOCK,
    S_WAIT,
    S_LOCK
  } state_t;

  state_t            r_state;
  logic [W_WIN-1:0]  r_win;
  logic [W_ERR-1:0]  r_err;
  logic [W_WAIT-1:0] r_wait;
  logic              r_slip;
  logic              r_lock;
  logic [15:0]       r_slip_cnt;
  logic [15:0]       r_loss_cnt;

  logic w_bad;
  logic w_win_last;
  logic w_err_last;
  logic w_wait_last;

  assign w_bad       = i_rx_header[1] ~^ i_rx_header[0];
  assign w_win_last  = (r_win  == W_WIN'(P_SH_WINDOW - 1));
  assign w_err_last  = (r_err  == W_ERR'(P_SH_INVLD_MAX - 1));
  assign w_wait_last = (r_wait == W_WAIT'(P_SLIP_WAIT - 1));

  function automatic logic [15:0] sat_inc(
    input logic [15:0] v
  );
    return (v == 16'hFFFF) ? v : v + 16'd1;
  endfunction

  always_ff @(posedge i_rx_clk) begin
    if (i_rx_rst) begin
      r_state    <= S_UNLOCK;
      r_win      <= '0;
      r_err      <= '0;
      r_wait     <= '0;
      r_slip     <= 1'b0;
      r_lock     <= 1'b0;
      r_slip_cnt <= '0;
      r_loss_cnt <= '0;
    end else begin
      r_slip <= 1'b0;
      if (i_rx_header_valid) begin
        case (r_state)
          S_UNLOCK: begin
            if (w_bad) begin
              r_slip     <= 1'b1;
              r_slip_cnt <= sat_inc(r_slip_cnt);
              r_win      <= '0;
              r_state    <= S_WAIT;
            end else if (w_win_last) begin
              r_lock  <= 1'b1;
              r_win   <= '0;
              r_err   <= '0;
              r_state <= S_LOCK;
            end else begin
              r_win <= r_win + W_WIN'(1);
            end
          end
          S_WAIT: begin
            if (w_wait_last) begin
              r_wait  <= '0;
              r_state <= S_UNLOCK;
            end else begin
              r_wait <= r_wait + W_WAIT'(1);
            end
          end
          S_LOCK: begin
            // threshold hit beats the end-of-window clear
            if (w_bad && w_err_last) begin
              r_lock     <= 1'b0;
              r_slip     <= 1'b1;
              r_slip_cnt <= sat_inc(r_slip_cnt);
              r_loss_cnt <= sat_inc(r_loss_cnt);
              r_win      <= '0;
              r_err      <= '0;
              r_state    <= S_WAIT;
            end else if (w_win_last) begin
              r_win <= '0;
              r_err <= '0;
            end else begin
              r_win <= r_win + W_WIN'(1);
              if (w_bad) begin
                r_err <= r_err + W_ERR'(1);
              end
            end
          end
          default: begin
            r_state <= S_UNLOCK;
          end
        endcase
      end
    end
  end

  assign o_rx_slipbit    = r_slip;
  assign o_block_lock    = r_lock;
  assign o_slip_cnt      = r_slip_cnt;
  assign o_lock_loss_cnt = r_loss_cnt;

endmodule

// File: tb/tb_rx_block_sync_ctrl.sv
// Scenario bench for rx_block_sync_ctrl.
// Expected output words are queued per clock and popped after the edge.
module tb_rx_block_sync_ctrl;

  localparam int K_F = 0;
  localparam int K_A = 1;
  localparam int K_G = 2;
  localparam int K_B = 3;
  localparam int K_R = 4;
  localparam int EV_NONE = 0;
  localparam int EV_LOCK = 1;
  localparam int EV_SLIP = 2;

  typedef struct {
    int kd;
    int n;
    int ev;
  } seg_t;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [15:0] slip_cnt;
  logic [15:0] loss_cnt;

  rx_block_sync_ctrl_if bus ();

  rx_block_sync_ctrl dut (
    .i_rx_clk          (clk),
    .i_rx_rst          (rst),
    .i_rx_header       (bus.header),
    .i_rx_header_valid (bus.header_valid),
    .o_rx_slipbit      (bus.slipbit),
    .o_block_lock      (bus.block_lock),
    .o_slip_cnt        (slip_cnt),
    .o_lock_loss_cnt   (loss_cnt)
  );

  always #5 clk = ~clk;

  int          chk = 0;
  int          errs = 0;
  int          ph = 0;
  int          cyc_n = 0;
  logic [33:0] q[$];
  logic [33:0] e;
  logic [33:0] obs;
  logic        e_lock;
  logic [15:0] e_sc;
  logic [15:0] e_lc;

  // 1-in-33 gearbox valid pattern
  function automatic logic gbv();
    logic v;
    v  = (ph != 32);
    ph = (ph == 32) ? 0 : ph + 1;
    return v;
  endfunction

  function automatic logic [1:0] good();
    return ($urandom_range(0, 1) != 0) ? 2'b01 : 2'b10;
  endfunction

  function automatic logic [1:0] bad();
    return ($urandom_range(0, 1) != 0) ? 2'b00 : 2'b11;
  endfunction

  task automatic cyc(input logic [1:0] h, input logic v);
    bus.header       = h;
    bus.header_valid = v;
    @(posedge clk);
    #1;
    obs = {bus.slipbit, bus.block_lock, slip_cnt, loss_cnt};
    cyc_n++;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    q.push_back(34'd0);
    cyc(2'b11, 1'b1);
    rst = 1'b0;
    e = q.pop_front();
    chk++;
    if (obs !== e) begin
      errs++;
      $display("FAIL reset_state clk %0d got %h want %h", cyc_n, obs, e);
    end
  endtask

  task automatic test_acquire();
    int  nv;
    int  n;
    logic v;
    rst = 1'b1;
    cyc(2'b00, 1'b1);
    rst = 1'b0;
    ph = 31;
    nv = 0;
    n  = 0;
    while (nv < 64) begin
      v = gbv();
      if (v) nv++;
      n++;
      q.push_back({1'b0, (nv == 64), 16'd0, 16'd0});
      cyc(v ? good() : bad(), v);
      e = q.pop_front();
      chk++;
      if (obs !== e) begin
        errs++;
        $display("FAIL acquire clk %0d got %h want %h", cyc_n, obs, e);
      end
    end
    chk++;
    if (n != 66) begin
      errs++;
      $display("FAIL acquire_clocks got %0d want 66", n);
    end
  endtask

  task automatic test_slip_recover();
    int  nv;
    logic v;
    logic [1:0] h;
    rst = 1'b1;
    cyc(2'b00, 1'b1);
    rst = 1'b0;
    ph = 0;
    nv = 0;
    while (nv < 97) begin
      v = gbv();
      if (v) nv++;
      h = !v ? bad() : (nv <= 3) ? 2'b11 : good();
      q.push_back({v && (nv == 1), (nv == 97), 16'(nv >= 1), 16'd0});
      cyc(h, v);
      e = q.pop_front();
      chk++;
      if (obs !== e) begin
        errs++;
        $display("FAIL slip_recover clk %0d got %h want %h", cyc_n, obs, e);
      end
    end
    e_lock = 1'b1;
    e_sc   = 16'd1;
    e_lc   = 16'd0;
  endtask

  task automatic test_lock_errors();
    int  k;
    int  idx;
    int  w;
    logic v;
    logic sl;
    logic isbad;
    logic [1:0] h;
    k = 0;
    while (k < 128) begin
      v  = gbv();
      sl = 1'b0;
      h  = bad();
      if (v) begin
        k++;
        idx   = (k - 1) % 64;
        w     = (k - 1) / 64;
        isbad = (w == 0) ? (idx % 4 == 1 && idx < 60) : (idx >= 48);
        h     = isbad ? bad() : good();
        if (k == 128) begin
          sl     = 1'b1;
          e_lock = 1'b0;
          e_sc++;
          e_lc++;
        end
      end
      q.push_back({sl, e_lock, e_sc, e_lc});
      cyc(h, v);
      e = q.pop_front();
      chk++;
      if (obs !== e) begin
        errs++;
        $display("FAIL lock_errors clk %0d got %h want %h", cyc_n, obs, e);
      end
    end
  endtask

  task automatic test_freeze();
    seg_t t[$];
    int   c;
    logic v;
    logic sl;
    logic [1:0] h;
    t = '{'{K_F, 100, EV_NONE}, '{K_A, 32, EV_NONE},
          '{K_G, 10, EV_NONE}, '{K_F, 100, EV_NONE},
          '{K_G, 54, EV_LOCK}, '{K_F, 100, EV_NONE}};
    foreach (t[s]) begin
      if (t[s].kd == K_F) begin
        repeat (t[s].n) begin
          q.push_back({1'b0, e_lock, e_sc, e_lc});
          cyc(2'($urandom), 1'b0);
          e = q.pop_front();
          chk++;
          if (obs !== e) begin
            errs++;
            $display("FAIL freeze_hold clk %0d got %h want %h", cyc_n, obs, e);
          end
        end
      end else begin
        c = 0;
        while (c < t[s].n) begin
          v  = gbv();
          sl = 1'b0;
          h  = 2'($urandom);
          if (v) begin
            c++;
            h = (t[s].kd == K_G) ? good() : bad();
            if (c == t[s].n && t[s].ev == EV_LOCK) e_lock = 1'b1;
          end
          q.push_back({sl, e_lock, e_sc, e_lc});
          cyc(h, v);
          e = q.pop_front();
          chk++;
          if (obs !== e) begin
            errs++;
            $display("FAIL freeze_run clk %0d got %h want %h", cyc_n, obs, e);
          end
        end
      end
    end
  endtask

  task automatic test_reset_mid();
    seg_t t[$];
    int   c;
    logic v;
    logic sl;
    logic [1:0] h;
    t = '{'{K_R, 1, EV_NONE}, '{K_B, 1, EV_SLIP},
          '{K_A, 10, EV_NONE}, '{K_R, 1, EV_NONE},
          '{K_G, 64, EV_LOCK}, '{K_B, 16, EV_SLIP},
          '{K_A, 32, EV_NONE}, '{K_G, 64, EV_LOCK},
          '{K_B, 5, EV_NONE}, '{K_R, 1, EV_NONE},
          '{K_G, 64, EV_LOCK}};
    foreach (t[s]) begin
      if (t[s].kd == K_R) begin
        rst    = 1'b1;
        e_lock = 1'b0;
        e_sc   = 16'd0;
        e_lc   = 16'd0;
        q.push_back(34'd0);
        cyc(bad(), 1'b1);
        rst = 1'b0;
        e = q.pop_front();
        chk++;
        if (obs !== e) begin
          errs++;
          $display("FAIL reset_mid clk %0d got %h want %h", cyc_n, obs, e);
        end
      end else begin
        c = 0;
        while (c < t[s].n) begin
          v  = gbv();
          sl = 1'b0;
          h  = 2'($urandom);
          if (v) begin
            c++;
            h = (t[s].kd == K_G) ? good() :
                (t[s].kd == K_B) ? bad() : 2'($urandom);
            if (c == t[s].n && t[s].ev == EV_LOCK) e_lock = 1'b1;
            if (c == t[s].n && t[s].ev == EV_SLIP) begin
              sl = 1'b1;
              e_sc++;
              if (e_lock) begin
                e_lock = 1'b0;
                e_lc++;
              end
            end
          end
          q.push_back({sl, e_lock, e_sc, e_lc});
          cyc(h, v);
          e = q.pop_front();
          chk++;
          if (obs !== e) begin
            errs++;
            $display("FAIL reset_reacq clk %0d got %h want %h", cyc_n, obs, e);
          end
        end
      end
    end
  endtask

  initial begin
    #1ms;
    $display("FAIL watchdog expired at clk %0d", cyc_n);
    $fatal(1, "watchdog");
  end

  initial begin
    bus.header       = 2'b00;
    bus.header_valid = 1'b0;
    e_lock = 1'b0;
    e_sc   = 16'd0;
    e_lc   = 16'd0;
    #2;
    test_reset();
    test_acquire();
    test_slip_recover();
    test_lock_errors();
    test_freeze();
    test_reset_mid();
    $display("CHECKS %0d ERRORS %0d", chk, errs);
    $finish;
  end

endmodule
